neural_neuron_mac_seq: RTL and testbench

Sequential, parametrised successor to the four-input combinational neuron core. It accepts one signed (x, w) pair per cycle over a valid/ready stream and multiplies through a registered pipeline stage. It accumulates N_INPUTS products plus a sign-extended bias into a full-precision signed sum, then presents the result on a valid/ready output port. It sits between the input/weight streamer and the activation/output buffer of the neuron layer.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/neuron_mult_stage.sv | 39 +++
 rtl/neural_neuron_mac_seq.sv | 130 +++++++++++++
 tb/tb_neural_neuron_mac_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron MAC.
// The state enum, the accumulator width rule and a generic sign-extension helper.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Width that holds N full-precision products plus a bias without overflow.
    function automatic int acc_width(input int n, input int d);
        return 2 * d + $clog2(n);
    endfunction

    // Replicate bit (w-1) of v into every bit above it.
    function automatic logic [63:0] sign_extend(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) begin
                r[i] = v[i];
            end else begin
                r[i] = v[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mult_stage.sv
// Registered signed DATA_W x DATA_W multiplier.
// p_vld follows in_vld by one cycle; p_reg holds its last product when no operand pair arrives.
module neuron_mult_stage #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   p_reg,
    output logic                  p_vld
);

    logic signed [2*DATA_W-1:0] a_ext_s;
    logic signed [2*DATA_W-1:0] b_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;

    // Widen both operands to product width so the multiply is full precision.
    always_comb begin
        a_ext_s = $signed({{DATA_W{a[DATA_W-1]}}, a});
        b_ext_s = $signed({{DATA_W{b[DATA_W-1]}}, b});
        prod_s  = a_ext_s * b_ext_s;
    end

    // Capture the product and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg <= {(2*DATA_W){1'b0}};
            p_vld <= 1'b0;
        end else begin
            p_vld <= in_vld;
            if (in_vld) begin
                p_reg <= prod_s;
            end
        end
    end

endmodule

// File: rtl/neural_neuron_mac_seq.sv
// Sequential neuron: accumulates N_INPUTS x*w products plus a bias, one beat per cycle.
// Optional feature macro NEURON_RELU_EN: clamps negative results to zero on the output port.
module neural_neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter  int N_INPUTS = 4,
    parameter  int DATA_W   = 8,
    localparam int ACC_W    = acc_width(N_INPUTS, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_x,
    input  logic [DATA_W-1:0] s_w,
    input  logic [DATA_W-1:0] s_bias,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_sum
);

    localparam int P_W   = 2 * DATA_W;
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    state_t              state_r;
    logic [ACC_W-1:0]    acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [P_W-1:0]      p_s;
    logic                p_vld_s;
    logic                beat_s;
    logic [ACC_W-1:0]    p_ext_s;
    logic [ACC_W-1:0]    bias_ext_s;
    logic [ACC_W-1:0]    sum_s;
    logic [ACC_W-1:0]    result_s;

    neuron_mult_stage #(.DATA_W(DATA_W)) u_mult (
        .clk    (clk),
        .rst    (rst),
        .in_vld (beat_s),
        .a      (s_x),
        .b      (s_w),
        .p_reg  (p_s),
        .p_vld  (p_vld_s)
    );

    // Input readiness depends on state alone; inputs are ignored in DRAIN and OUT.
    always_comb begin
        case (state_r)
            ST_IDLE:  s_ready = 1'b1;
            ST_ACCUM: s_ready = 1'b1;
            default:  s_ready = 1'b0;
        endcase
        beat_s = s_valid && s_ready;
    end

    // Sign-extend operands and form the running sum; only a valid product is added.
    always_comb begin
        p_ext_s    = ACC_W'(sign_extend({{(64-P_W){1'b0}}, p_s}, P_W));
        bias_ext_s = ACC_W'(sign_extend({{(64-DATA_W){1'b0}}, s_bias}, DATA_W));
        if (p_vld_s) begin
            sum_s = acc_r + p_ext_s;
        end else begin
            sum_s = acc_r;
        end
    end

`ifdef NEURON_RELU_EN
    // Clamp negative sums to zero for the output port only.
    always_comb begin
        if (sum_s[ACC_W-1]) begin
            result_s = {ACC_W{1'b0}};
        end else begin
            result_s = sum_s;
        end
    end
`else
    // Present the raw signed sum.
    always_comb begin
        result_s = sum_s;
    end
`endif

    // Control FSM with accumulator, beat counter and registered result port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            m_valid <= 1'b0;
            m_sum   <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (beat_s) begin
                        acc_r   <= bias_ext_s;
                        cnt_r   <= CNT_W'(1);
                        state_r <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_r <= sum_s;
                    if (beat_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    acc_r   <= sum_s;
                    m_sum   <= result_s;
                    m_valid <= 1'b1;
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neural_neuron_mac_seq.sv
// Scoreboard bench for neural_neuron_mac_seq at default parameters.
module tb_neural_neuron_mac_seq;

    typedef int vec_t [4];

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_x;
    logic [7:0]  s_w;
    logic [7:0]  s_bias;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_sum;

    int checks;
    int errors;
    int exp_q [$];

    neural_neuron_mac_seq #(.N_INPUTS(4), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_x     (s_x),
        .s_w     (s_w),
        .s_bias  (s_bias),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sum   (m_sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", int'($signed(m_sum)), -999999);
            end else begin
                check("m_sum", int'($signed(m_sum)), exp_q.pop_front());
            end
        end
    end

    task automatic beat(input int x, input int w, input int b);
        s_valid = 1'b1;
        s_x     = 8'(x);
        s_w     = 8'(w);
        s_bias  = 8'(b);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t xv, input vec_t wv, input int b);
        for (int i = 0; i < 4; i++) begin
            beat(xv[i], wv[i], b);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(s_ready && !m_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("idle_timeout", 0, 1);
    endtask

    vec_t x1, w1, xneg, wneg, wpos;
    int   exp3;

    initial begin
        x1   = '{1, 2, 3, 4};
        w1   = '{5, 6, 7, 8};
        xneg = '{-128, -128, -128, -128};
        wneg = '{-128, -128, -128, -128};
        wpos = '{127, 127, 127, 127};
`ifdef NEURON_RELU_EN
        exp3 = 0;
`else
        exp3 = -65152;
`endif
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_x     = 8'd0;
        s_w     = 8'd0;
        s_bias  = 8'd0;
        m_ready = 1'b1;
        #2;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_sum", int'(m_sum), 0);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic vector and latency
        exp_q.push_back(80);
        send_vec(x1, w1, 10);
        check("lat_c1_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        check("lat_c2_m_valid", m_valid, 1);
        wait_idle();

        // Largest positive sum
        exp_q.push_back(65663);
        send_vec(xneg, wneg, 127);
        wait_idle();

        // Most negative sum
        exp_q.push_back(exp3);
        send_vec(xneg, wpos, -128);
        wait_idle();

        // Gap of three idle cycles between beats 1 and 2
        exp_q.push_back(80);
        beat(1, 5, 10);
        beat(2, 6, 10);
        for (int g = 0; g < 3; g++) begin
            @(posedge clk);
            #1;
            check("gap_acc", int'($signed(dut.acc_r)), 27);
        end
        beat(3, 7, 10);
        beat(4, 8, 10);
        wait_idle();

        // Output backpressure then immediate new vector
        m_ready = 1'b0;
        exp_q.push_back(80);
        send_vec(x1, w1, 10);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("hold_m_valid", m_valid, 1);
            check("hold_m_sum", int'($signed(m_sum)), 80);
            check("hold_s_ready", s_ready, 0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_s_ready", s_ready, 1);
        check("post_hs_m_valid", m_valid, 0);
        exp_q.push_back(65663);
        send_vec(xneg, wneg, 127);
        wait_idle();

        // Reset in the middle of a vector
        beat(1, 5, 10);
        beat(2, 6, 10);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_sum", int'(m_sum), 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_acc", int'(dut.acc_r), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(80);
        send_vec(x1, w1, 10);
        wait_idle();

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            @(posedge clk);
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
